// File: rtl/eight_bit_reset_reg_pkg.sv
// eight_bit_reset_reg_pkg: shared defaults for the clearable parallel-load register
//   DEFAULT_WIDTH        default data width in bits
//   DEFAULT_RESET_VALUE  default value loaded by clear (8 bits, resized per instance)
package eight_bit_reset_reg_pkg;

    localparam int          DEFAULT_WIDTH       = 8;
    localparam logic [7:0]  DEFAULT_RESET_VALUE = 8'h00;

endpackage

// File: rtl/eight_bit_reset_reg_if.sv
// eight_bit_reset_reg_if: data bus of the clearable register
//   IN   parallel data presented to the register (driven by master)
//   OUT  registered data returned by the register (driven by slave)
interface eight_bit_reset_reg_if
    import eight_bit_reset_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] IN;
    logic [WIDTH-1:0] OUT;

    modport master (output IN, input OUT);
    modport slave  (input IN, output OUT);

endinterface

// File: rtl/eight_bit_reset_reg_dff_sync_clr.sv
// dff_sync_clr: 1-bit D flop with synchronous active-high clear
//   clk    clock, rising edge
//   clear  synchronous clear, loads RST_BIT
//   d_i    data input
//   q_o    registered output
module dff_sync_clr #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic clear,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (clear)
            q_q <= RST_BIT;
        else
            q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/eight_bit_reset_reg.sv
// eight_bit_reset_reg: parallel-load register with synchronous clear, loads every cycle
//   clk    clock, rising edge
//   clear  synchronous active-high clear, loads RESET_VALUE and overrides IN
//   bus    slave side of eight_bit_reset_reg_if: IN captured each edge, OUT straight from flops
module eight_bit_reset_reg
    import eight_bit_reset_reg_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic                        clk,
    input  logic                        clear,
    eight_bit_reset_reg_if.slave        bus
);

    logic [WIDTH-1:0] out_q;

    // One flop per bit; each bit carries its own slice of the clear value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_sync_clr #(
            .RST_BIT (RESET_VALUE[i])
        ) u_dff (
            .clk   (clk),
            .clear (clear),
            .d_i   (bus.IN[i]),
            .q_o   (out_q[i])
        );
    end

    assign bus.OUT = out_q;

endmodule

// File: tb/tb_eight_bit_reset_reg.sv
// tb_eight_bit_reset_reg: table vectors, hand sequences and randomized model check
module tb_eight_bit_reset_reg;

    typedef struct {
        logic       clr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
    logic clear4 = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    eight_bit_reset_reg_if #(.WIDTH(8)) bus8();
    eight_bit_reset_reg_if #(.WIDTH(4)) bus4();

    eight_bit_reset_reg dut8 (
        .clk   (clk),
        .clear (clear),
        .bus   (bus8.slave)
    );

    eight_bit_reset_reg #(
        .WIDTH       (4),
        .RESET_VALUE (4'hA)
    ) dut4 (
        .clk   (clk),
        .clear (clear4),
        .bus   (bus4.slave)
    );

    task automatic chk8(input string name, input logic [7:0] exp);
        vectors++;
        if (bus8.OUT !== exp) begin
            miscompares++;
            $display("FAIL %s: OUT=%h expected %h", name, bus8.OUT, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] exp);
        vectors++;
        if (bus4.OUT !== exp) begin
            miscompares++;
            $display("FAIL %s: OUT=%h expected %h", name, bus4.OUT, exp);
        end
    endtask

    task automatic step8(input logic clr, input logic [7:0] din);
        @(negedge clk);
        clear = clr;
        bus8.IN = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[8];
        logic [7:0] q[$];
        logic [7:0] exp;
        logic [7:0] last;
        logic clr;
        logic [7:0] din;
        tbl[0] = '{1'b1, 8'h5C, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 8'h00};
        tbl[2] = '{1'b0, 8'hAA, 8'hAA};
        tbl[3] = '{1'b0, 8'hFF, 8'hFF};
        tbl[4] = '{1'b1, 8'hFF, 8'h00};
        tbl[5] = '{1'b1, 8'hFF, 8'h00};
        tbl[6] = '{1'b1, 8'hFF, 8'h00};
        tbl[7] = '{1'b0, 8'h04, 8'h04};
        bus8.IN = 8'h00;
        bus4.IN = 4'h0;
        for (int i = 0; i < 4; i++) begin
            step8(tbl[i].clr, tbl[i].din);
            chk8($sformatf("table%0d", i), tbl[i].exp);
        end
        // clear raised mid-cycle must not disturb OUT before the next edge
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk8("clear_midcycle_hold", 8'hFF);
        @(posedge clk);
        #1;
        chk8("clear_after_edge", 8'h00);
        for (int i = 4; i < 8; i++) begin
            step8(tbl[i].clr, tbl[i].din);
            chk8($sformatf("table%0d", i), tbl[i].exp);
        end
        // clear dropped mid-cycle must not load IN until the edge
        step8(1'b1, 8'h77);
        @(negedge clk);
        clear = 1'b0;
        bus8.IN = 8'h3C;
        #1;
        chk8("unclear_midcycle_hold", 8'h00);
        @(posedge clk);
        #1;
        chk8("unclear_after_edge", 8'h3C);
        // 4-bit instance with a non-zero clear value
        @(negedge clk);
        clear4 = 1'b1;
        bus4.IN = 4'h3;
        @(posedge clk);
        #1;
        chk4("w4_clear", 4'hA);
        @(negedge clk);
        clear4 = 1'b0;
        bus4.IN = 4'h5;
        @(posedge clk);
        #1;
        chk4("w4_load", 4'h5);
        // randomized run: OUT is last edge's IN, or the clear value if clear was high
        last = bus8.OUT;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk8("rand_stable", last);
            clr = ($urandom_range(3) == 0);
            din = 8'($urandom);
            clear = clr;
            bus8.IN = din;
            q.push_back(clr ? 8'h00 : din);
            @(posedge clk);
            #1;
            exp = q.pop_front();
            chk8("rand", exp);
            last = exp;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
